// File: rtl/matriz_pkg.sv
// Shared constants and helpers for the LED-matrix framebuffer/scanner.
package matriz_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int ROWS_DEF      = 8;
  localparam int LANES_DEF     = 4;
  localparam int CW_DEF        = 3;

  // Bits needed to index n items; never less than one bit.
  function automatic int col_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Reference lane-to-frame mapping for the default geometry.
  // Row r, column c is the OR of bit r of every lane placed at column c.
  function automatic logic [ROWS_DEF*DATAWIDTH_DEF-1:0] map_lanes(
    input logic [LANES_DEF*ROWS_DEF-1:0] lanes,
    input logic [LANES_DEF*CW_DEF-1:0]   pos
  );
    logic [ROWS_DEF*DATAWIDTH_DEF-1:0] f;
    logic [LANES_DEF*ROWS_DEF-1:0]     l;
    logic [LANES_DEF*CW_DEF-1:0]       p;
    int c;
    f = '0;
    for (int k = 0; k < LANES_DEF; k++) begin
      p = pos >> (k * CW_DEF);
      c = int'(p[CW_DEF-1:0]);
      if (c < DATAWIDTH_DEF) begin
        for (int r = 0; r < ROWS_DEF; r++) begin
          l = lanes >> (k * ROWS_DEF + r);
          f = f | ((ROWS_DEF*DATAWIDTH_DEF)'(l[0]) << (r * DATAWIDTH_DEF + c));
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/matriz_lane_mapper.sv
// Combinational placement of column-lane words into a full row-major frame.
module matriz_lane_mapper
  import matriz_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int LANES     = LANES_DEF,
  parameter logic [LANES*col_width(DATAWIDTH)-1:0] LANE_POS = {3'd7, 3'd6, 3'd1, 3'd0}
) (
  input  logic [LANES*ROWS-1:0]     lanes,
  output logic [ROWS*DATAWIDTH-1:0] frame
);

  localparam int CW = col_width(DATAWIDTH);

  // Each frame bit ORs the matching row bit of every lane placed at its column;
  // lanes positioned beyond the matrix width never match any column.
  genvar gi, gc, gk;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gc = 0; gc < DATAWIDTH; gc++) begin : g_col
        logic [LANES-1:0] hit;
        for (gk = 0; gk < LANES; gk++) begin : g_lane
          assign hit[gk] = lanes[gk*ROWS+gi] & (LANE_POS[gk*CW +: CW] == CW'(gc));
        end
        assign frame[gi*DATAWIDTH+gc] = |hit;
      end
    end
  endgenerate

endmodule

// File: rtl/matriz_scan.sv
// Double-buffered LED-matrix framebuffer with multiplexed row scanner.
// New frames are staged in a back buffer and swapped to the front only at
// frame boundaries so a partial frame is never shown.
module matriz_scan
  import matriz_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int LANES     = LANES_DEF,
  parameter logic [LANES*col_width(DATAWIDTH)-1:0] LANE_POS = {3'd7, 3'd6, 3'd1, 3'd0},
  parameter int SCAN_DIV  = 50000
) (
  input  logic                      MatrizScan_CLOCK_50,
  input  logic                      MatrizScan_RESET_InHigh,
  input  logic [LANES*ROWS-1:0]     MatrizScan_Lane_In,
  input  logic                      MatrizScan_LoadValid_In,
  output logic                      MatrizScan_LoadReady_Out,
  input  logic                      MatrizScan_Blank_In,
  output logic [ROWS-1:0]           MatrizScan_RowSel_Out,
  output logic [DATAWIDTH-1:0]      MatrizScan_Col_Out,
  output logic [ROWS*DATAWIDTH-1:0] MatrizScan_Frame_Out,
  output logic                      MatrizScan_FrameDone_Out
);

  localparam int RW = col_width(ROWS);
  localparam int PW = col_width(SCAN_DIV);

  logic                      clk;
  logic                      rst;
  logic [ROWS*DATAWIDTH-1:0] mapped;
  logic [ROWS*DATAWIDTH-1:0] back_reg;
  logic [ROWS*DATAWIDTH-1:0] front_reg;
  logic                      pending_reg;
  logic [RW-1:0]             row_reg;
  logic [PW-1:0]             presc_reg;
  logic                      blank_reg;
  logic                      frame_done_reg;
  logic                      accept;
  logic                      row_tick;
  logic                      frame_end;
  logic [DATAWIDTH-1:0]      front_rows [ROWS];

  assign clk = MatrizScan_CLOCK_50;
  assign rst = MatrizScan_RESET_InHigh;

  matriz_lane_mapper #(
    .DATAWIDTH (DATAWIDTH),
    .ROWS      (ROWS),
    .LANES     (LANES),
    .LANE_POS  (LANE_POS)
  ) u_mapper (
    .lanes (MatrizScan_Lane_In),
    .frame (mapped)
  );

  // Handshake and scan timing decode.
  always_comb begin
    accept    = MatrizScan_LoadValid_In && !pending_reg;
    row_tick  = (presc_reg == PW'(SCAN_DIV - 1));
    frame_end = row_tick && (row_reg == RW'(ROWS - 1));
  end

  // Buffers, pending flag, prescaler, row counter and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      back_reg       <= '0;
      front_reg      <= '0;
      pending_reg    <= 1'b0;
      row_reg        <= '0;
      presc_reg      <= '0;
      blank_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      presc_reg <= row_tick ? '0 : presc_reg + PW'(1);
      if (row_tick) begin
        row_reg <= frame_end ? '0 : row_reg + RW'(1);
      end
      if (accept) begin
        back_reg <= mapped;
      end
      // A swap needs a frame already pending before this edge; an accept
      // on the frame-end edge only arms the next frame boundary.
      if (frame_end && pending_reg) begin
        front_reg   <= back_reg;
        pending_reg <= 1'b0;
      end else if (accept) begin
        pending_reg <= 1'b1;
      end
      frame_done_reg <= frame_end;
      blank_reg      <= MatrizScan_Blank_In;
    end
  end

  // Row-sliced view of the front buffer and one-hot row decode.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_out
      assign front_rows[gi]            = front_reg[gi*DATAWIDTH +: DATAWIDTH];
      assign MatrizScan_RowSel_Out[gi] = (row_reg == RW'(gi));
    end
  endgenerate

  // Output drive: blanking forces the column word to zero without pausing the scan.
  always_comb begin
    MatrizScan_LoadReady_Out = !pending_reg;
    MatrizScan_Col_Out       = blank_reg ? '0 : front_rows[row_reg];
    MatrizScan_Frame_Out     = front_reg;
    MatrizScan_FrameDone_Out = frame_done_reg;
  end

endmodule

// File: doc/matriz_scan.md
# matriz_scan

Registered, double-buffered LED-matrix framebuffer and row scanner. It replaces the purely combinational lane-to-row mapping. It accepts LANES column-lane words through a valid/ready handshake and places each lane at a parametrised column. New frames swap in only at frame boundaries, so no partial frame is ever displayed. The block drives a one-hot row strobe and its column word for multiplexed matrices, and also exposes the whole front frame for statically driven displays.

## Interface
- DATAWIDTH, 8: matrix columns (bits per row)
- ROWS, 8: matrix rows (bits per lane word)
- LANES, 4: number of column lanes
- LANE_POS, {3'd7,3'd6,3'd1,3'd0}: packed column index per lane, lane 0 in LSBs, $clog2(DATAWIDTH) bits each
- SCAN_DIV, 50000: clock cycles per displayed row (≥2)
- MatrizScan_CLOCK_50  in  1  system clock; sole clock, all state on its rising edge
- MatrizScan_RESET_InHigh  in  1  asynchronous, active-high reset
- MatrizScan_Lane_In  in  LANES*ROWS  lane words; lane k at [k*ROWS +: ROWS]; bit r → row r
- MatrizScan_LoadValid_In  in  1  lane words valid
- MatrizScan_LoadReady_Out  out  1  back buffer free
- MatrizScan_Blank_In  in  1  force column output to zero
- MatrizScan_RowSel_Out  out  ROWS  one-hot active row, active high
- MatrizScan_Col_Out  out  DATAWIDTH  column word of active row
- MatrizScan_Frame_Out  out  ROWS*DATAWIDTH  front frame; row r at [r*DATAWIDTH +: DATAWIDTH]
- MatrizScan_FrameDone_Out  out  1  one-cycle pulse per completed frame

## Operation
- Mapping: row r, column c = OR of bit r over every lane k with LANE_POS[k]==c. Unmapped columns are 0. A lane with LANE_POS ≥ DATAWIDTH is ignored.
- Buffers: back buffer (mapped frame) and front buffer (displayed), plus a `pending` flag.
- LoadReady_Out = !pending (combinational).
- Accept on an edge with LoadValid_In && LoadReady_Out: the back buffer captures the mapped frame and `pending` sets. LoadValid_In without Ready is ignored; no data is held.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - A row tick occurs when the prescaler is at SCAN_DIV-1.
  - On a row tick the row counter advances, wrapping ROWS-1 → 0.
- Frame end: a row tick while row == ROWS-1. If `pending` was already set before that edge:
  - front ← back and `pending` clears on the same edge.
  - An accept on that same edge does not swap; it sets `pending` and waits for the next frame end.
- FrameDone_Out: registered; high for the one cycle following every frame-end edge, whether or not a swap occurred.
- RowSel_Out = one-hot of the row counter.
- Col_Out = blank_q ? 0 : front[row]. blank_q is Blank_In registered.
- Frame_Out = front buffer.
- Reset (async, any time, including mid-frame):
  - front, back, `pending`, row, prescaler, blank_q and FrameDone_Out all clear to 0.
  - RowSel_Out = 1 (row 0); Col_Out = 0; Frame_Out = 0; LoadReady_Out = 1.
  - No accept occurs while reset is asserted.

## Timing
- Accept → LoadReady_Out low: the cycle after the accepting edge.
- Swap latency: the first frame-end edge strictly after the accept. Worst case ROWS*SCAN_DIV cycles.
- Swap edge: RowSel_Out = row 0 and Col_Out shows new-frame row 0 together, on the same edge.
- Row dwell: exactly SCAN_DIV cycles, starting from reset release.
- Frame period: ROWS*SCAN_DIV cycles.
- Blank_In → Col_Out: 1-cycle latency; does not affect the scan.

## Structure
- Package matriz_pkg:
  - localparam defaults for DATAWIDTH/ROWS/LANES.
  - Column-index width function clog2 helper.
  - Mapping function map_lanes(lanes, pos) → ROWS*DATAWIDTH frame.
- Sub-module matriz_lane_mapper: combinational lane→frame mapping, instantiated once feeding the back buffer.
- Top level holds the buffers, handshake, prescaler, row counter and output logic.

## Test plan
All scenarios use DATAWIDTH=8, ROWS=8, LANES=4, SCAN_DIV=4 and default LANE_POS.
- Reset mid-frame → RowSel=8'h01, Col=0, Frame=0, Ready=1, FrameDone=0. Row 1 appears exactly 4 cycles after release.
- Load Lane_In={8'h80,8'h00,8'h02,8'h01} → Ready falls next cycle. At the next frame end, Frame row0=8'h01, row1=8'h02, row7=8'h80, others 0. Col=8'h01 while RowSel=8'h01.
- Second LoadValid while pending with different data → not accepted; the first frame is displayed. Ready returns high after the swap.
- Lanes 0 and 1 both set to position 3, lane words 8'h01 and 8'h02 → row0=8'h08, row1=8'h08.
- Accept on the exact frame-end edge → no swap that frame; FrameDone pulses; the swap occurs 32 cycles later.
- Blank_In high → Col=0 one cycle later while RowSel keeps scanning. Release → data returns one cycle later.
